// File: rtl/dhs_apb_mem_bist_pkg.sv
// -----------------------------------------------------------------------------
// dual_helix_pkg
// Shared types and constants for the APB memory BIST master.
//   dhs_bist_mode_e  : data pattern selector driven on mode_i
//   dhs_bist_stride  : byte stride between consecutive words for a data width
//   DHS_BIST_STRIDE  : stride for the default 32-bit data path
// -----------------------------------------------------------------------------
package dual_helix_pkg;

  typedef enum logic [1:0] {
    DHS_BIST_INCR     = 2'd0,  // seed + i
    DHS_BIST_WALK1    = 2'd1,  // 1 << (i mod DATA_W)
    DHS_BIST_ADDR     = 2'd2,  // word address
    DHS_BIST_INV_INCR = 2'd3   // ~(seed + i)
  } dhs_bist_mode_e;

  function automatic int unsigned dhs_bist_stride(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned DHS_BIST_DATA_W = 32;
  localparam int unsigned DHS_BIST_STRIDE = dhs_bist_stride(DHS_BIST_DATA_W);

endpackage

// File: rtl/dhs_apb_mem_bist_pattern_gen.sv
// -----------------------------------------------------------------------------
// dhs_bist_pattern_gen
// Purely combinational pattern source for the BIST master. One instance feeds
// both the write data and the read expectation so the two can never diverge.
// Ports:
//   mode_i  : pattern selector
//   seed_i  : pattern seed (INCR / INV_INCR)
//   idx_i   : word index i
//   addr_i  : byte address of word i (ADDR pattern)
//   data_o  : pattern word
// -----------------------------------------------------------------------------
module dhs_bist_pattern_gen
  import dual_helix_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  dhs_bist_mode_e    mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [CNT_W-1:0]  idx_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] incr;
  logic [31:0]       walk_pos;

  // NOTE: every signal driven here gets a value before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    incr     = seed_i + DATA_W'(idx_i);
    walk_pos = 32'(idx_i) % DATA_W;
    data_o   = '0;
    case (mode_i)
      DHS_BIST_INCR:     data_o = incr;
      DHS_BIST_WALK1:    data_o = DATA_W'(1) << walk_pos;
      DHS_BIST_ADDR:     data_o = DATA_W'(addr_i);
      DHS_BIST_INV_INCR: data_o = ~incr;
      default:           data_o = '0;
    endcase
  end

endmodule

// File: rtl/dhs_apb_mem_bist.sv
// -----------------------------------------------------------------------------
// dhs_apb_mem_bist
// APB master that writes a pattern over a word range, reads it back and
// compares, in interleaved (W0,R0,W1,R1..) or block (all W, then all R) order.
// Ports:
//   clk_i, arst_i           : clock, asynchronous active-high reset
//   start_i                 : 1-cycle start, honoured only while idle
//   mode_i, block_i         : pattern select, ordering select
//   base_addr_i, num_words_i, seed_i : run configuration, latched at start
//   psel_o .. pstrb_o       : APB request (address/data fields registered)
//   prdata_i, pready_i, pslverr_i    : APB response
//   busy_o, done_o          : run in progress, 1-cycle completion pulse
//   pass_o, timeout_o       : result flags, valid from done until next start
//   err_cnt_o               : saturating error count
//   fail_addr_o, fail_data_o: first failing address and read data
// -----------------------------------------------------------------------------
module dhs_apb_mem_bist
  import dual_helix_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  start_i,
  input  dhs_bist_mode_e        mode_i,
  input  logic                  block_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [CNT_W-1:0]      num_words_i,
  input  logic [DATA_W-1:0]     seed_i,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic [ADDR_W-1:0]     paddr_o,
  output logic                  pwrite_o,
  output logic [DATA_W-1:0]     pwdata_o,
  output logic [DATA_W/8-1:0]   pstrb_o,
  input  logic [DATA_W-1:0]     prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [ADDR_W-1:0]     fail_addr_o,
  output logic [DATA_W-1:0]     fail_data_o
);

  localparam int unsigned       STRB_W   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(dhs_bist_stride(DATA_W));
  localparam int unsigned       TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  // GAP is the mandatory idle cycle between transfers; it is also where the
  // registered request fields for the next transfer are loaded.
  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP, ST_DONE
  } state_e;

  state_e              state_q, state_d;
  dhs_bist_mode_e      mode_q, mode_d;
  logic                block_q, block_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                phase_q, phase_d;          // 0 = write, 1 = read
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;  // base + idx*STRIDE
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                timeout_q, timeout_d;
  logic                pass_q, pass_d;

  // Pattern generator inputs: live configuration while idle (to prepare the
  // first write on the start edge), latched configuration otherwise.
  dhs_bist_mode_e    gen_mode;
  logic [DATA_W-1:0] gen_seed;
  logic [CNT_W-1:0]  gen_idx;
  logic [ADDR_W-1:0] gen_addr;
  logic [DATA_W-1:0] gen_data;

  assign gen_mode = (state_q == ST_IDLE) ? mode_i      : mode_q;
  assign gen_seed = (state_q == ST_IDLE) ? seed_i      : seed_q;
  assign gen_idx  = (state_q == ST_IDLE) ? '0          : idx_q;
  assign gen_addr = (state_q == ST_IDLE) ? base_addr_i : word_addr_q;

  dhs_bist_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_pattern_gen (
    .mode_i (gen_mode),
    .seed_i (gen_seed),
    .idx_i  (gen_idx),
    .addr_i (gen_addr),
    .data_o (gen_data)
  );

  logic last_idx;
  logic last_xfer;
  logic xfer_err;

  assign last_idx  = (idx_q == num_q - CNT_W'(1));
  assign last_xfer = phase_q && last_idx;  // every run ends on the read of word n-1
  assign xfer_err  = pslverr_i || (phase_q && (prdata_i != gen_data));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    block_d     = block_q;
    seed_d      = seed_q;
    base_d      = base_q;
    num_d       = num_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    word_addr_d = word_addr_q;
    tmo_d       = tmo_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d      = mode_i;
          block_d     = block_i;
          seed_d      = seed_i;
          base_d      = base_addr_i;
          num_d       = num_words_i;
          idx_d       = '0;
          phase_d     = 1'b0;
          word_addr_d = base_addr_i;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
          if (num_words_i == '0) begin
            pass_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            paddr_d  = base_addr_i;
            pwrite_d = 1'b1;
            pwdata_d = gen_data;
            pstrb_d  = '1;
            state_d  = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        tmo_d   = '0;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready_i) begin
          if (xfer_err) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (err_cnt_q == '0) begin
              fail_addr_d = paddr_q;
              fail_data_d = phase_q ? prdata_i : '0;
            end
          end
          // Advance to the next (word, direction) pair.
          if (!phase_q && !block_q) begin
            phase_d = 1'b1;
          end else if (!phase_q && last_idx) begin
            phase_d     = 1'b1;
            idx_d       = '0;
            word_addr_d = base_q;
          end else begin
            idx_d       = idx_q + CNT_W'(1);
            word_addr_d = word_addr_q + STRIDE;
            if (!block_q) phase_d = 1'b0;
          end
          if (last_xfer) begin
            pass_d  = (err_cnt_d == '0);
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
          end
        end else if ((TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST)) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_GAP: begin
        paddr_d  = word_addr_q;
        pwrite_d = ~phase_q;
        pwdata_d = phase_q ? '0 : gen_data;
        pstrb_d  = phase_q ? '0 : '1;
        state_d  = ST_SETUP;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= DHS_BIST_INCR;
      block_q     <= 1'b0;
      seed_q      <= '0;
      base_q      <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      word_addr_q <= '0;
      tmo_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      block_q     <= block_d;
      seed_q      <= seed_d;
      base_q      <= base_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      word_addr_q <= word_addr_d;
      tmo_q       <= tmo_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
    end
  end

  assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o   = (state_q == ST_ACCESS);
  assign busy_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS) || (state_q == ST_GAP);
  assign done_o      = (state_q == ST_DONE);
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign err_cnt_o   = err_cnt_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: tb/tb_dhs_apb_mem_bist.sv
// -----------------------------------------------------------------------------
// tb_dhs_apb_mem_bist
// Directed bench for dhs_apb_mem_bist: an APB RAM model with configurable wait
// states, read corruption, write error injection and a never-ready mode, plus
// protocol monitoring (SETUP length, request stability, idle gap).
// -----------------------------------------------------------------------------
module tb_dhs_apb_mem_bist;
  import dual_helix_pkg::*;

  logic           clk_i = 1'b0;
  logic           arst_i;
  logic           start_i;
  dhs_bist_mode_e mode_i;
  logic           block_i;
  logic [31:0]    base_addr_i;
  logic [15:0]    num_words_i;
  logic [31:0]    seed_i;
  logic           psel_o, penable_o, pwrite_o;
  logic [31:0]    paddr_o, pwdata_o;
  logic [3:0]     pstrb_o;
  logic [31:0]    prdata_i;
  logic           pready_i, pslverr_i;
  logic           busy_o, done_o, pass_o, timeout_o;
  logic [15:0]    err_cnt_o;
  logic [31:0]    fail_addr_o, fail_data_o;

  dhs_apb_mem_bist #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(16), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .start_i(start_i), .mode_i(mode_i),
    .block_i(block_i), .base_addr_i(base_addr_i), .num_words_i(num_words_i),
    .seed_i(seed_i), .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_cnt_o(err_cnt_o), .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } xfer_t;

  xfer_t       log_q[$];
  logic [31:0] mem [logic [31:0]];

  int          wait_states = 0;
  bit          hang = 0;
  bit          corrupt_en = 0;
  logic [31:0] corrupt_addr = '0;
  bit          wr_err_en = 0;
  logic [31:0] wr_err_addr = '0;
  int          wait_cnt = 0;
  bit          last_cmp = 0;
  bit          prev_setup = 0;
  logic [68:0] setup_vec = '0;
  int          proto_viol = 0;
  int          acc_cycles = 0;
  int          psel_cycles = 0;

  // APB target model and protocol monitor, evaluated mid-cycle.
  always @(negedge clk_i) begin
    if (last_cmp && psel_o) proto_viol++;
    if (psel_o) psel_cycles++;
    if (psel_o && penable_o) begin
      acc_cycles++;
      if ({paddr_o, pwrite_o, pwdata_o, pstrb_o} !== setup_vec) proto_viol++;
      if (hang || wait_cnt < wait_states) begin
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        wait_cnt++;
      end else begin
        pready_i  = 1'b1;
        wait_cnt  = 0;
        pslverr_i = wr_err_en && pwrite_o && (paddr_o == wr_err_addr);
        if (pwrite_o) begin
          mem[paddr_o] = pwdata_o;
          prdata_i     = 32'hBAD0_BAD0;
          log_q.push_back('{1'b1, paddr_o, pwdata_o, pstrb_o});
        end else begin
          prdata_i = mem.exists(paddr_o) ? mem[paddr_o] : 32'h0;
          if (corrupt_en && paddr_o == corrupt_addr) prdata_i[0] = 1'b1;
          log_q.push_back('{1'b0, paddr_o, prdata_i, pstrb_o});
        end
      end
    end else begin
      if (psel_o) begin
        if (prev_setup) proto_viol++;
        setup_vec = {paddr_o, pwrite_o, pwdata_o, pstrb_o};
      end
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      wait_cnt  = 0;
    end
    prev_setup = psel_o && !penable_o;
    last_cmp   = psel_o && penable_o && pready_i;
  end

  function automatic logic [154:0] out_vec();
    return {psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o, busy_o,
            done_o, pass_o, timeout_o, err_cnt_o, fail_addr_o, fail_data_o};
  endfunction

  // Launch one run and wait (bounded) for done_o. cyc is the number of cycles
  // from the start edge to the DONE cycle (0 if it never came). A second start
  // pulse with a different configuration is injected at cycle 'repulse'.
  task automatic run(input dhs_bist_mode_e mode, input logic blk,
                     input logic [31:0] base, input logic [15:0] n,
                     input logic [31:0] seed, input int repulse,
                     output int cyc, output logic busy_c1);
    log_q.delete();
    proto_viol  = 0;
    acc_cycles  = 0;
    psel_cycles = 0;
    busy_c1     = 1'b0;
    @(negedge clk_i);
    mode_i = mode; block_i = blk; base_addr_i = base; num_words_i = n;
    seed_i = seed; start_i = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 4000; i++) begin
      @(negedge clk_i);
      start_i = (i == repulse);
      if (i == repulse) begin
        num_words_i = 16'd9;
        base_addr_i = 32'hDEAD_0000;
      end
      if (i == 1) busy_c1 = busy_o;
      if (done_o === 1'b1) begin
        cyc = i;
        break;
      end
    end
    checks++;
    if (cyc == 0) begin
      errors++;
      $display("FAIL done_wait: done_o not seen within 4000 cycles");
    end
  endtask

  task automatic test_reset();
    arst_i = 1'b1; start_i = 1'b0; mode_i = DHS_BIST_INCR; block_i = 1'b0;
    base_addr_i = '0; num_words_i = '0; seed_i = '0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (out_vec() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", out_vec());
    end
    arst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (out_vec() !== '0) begin
      errors++; $display("FAIL idle_outputs: got %h expected 0", out_vec());
    end
  endtask

  task automatic test_incr_interleaved();
    int cyc; logic b1; logic [31:0] ea, ed;
    run(DHS_BIST_INCR, 1'b0, 32'h8000_0000, 16'd32, 32'h1234_5678, 0, cyc, b1);
    checks++;
    if (cyc !== 192) begin errors++; $display("FAIL incr_latency: got %0d expected 192", cyc); end
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL incr_busy: got %b expected 1", b1); end
    checks++;
    if (log_q.size() != 64) begin errors++; $display("FAIL incr_xfer_count: got %0d expected 64", log_q.size()); end
    for (int k = 0; k < 64 && k < log_q.size(); k++) begin
      ea = 32'h8000_0000 + 32'((k / 2) * DHS_BIST_STRIDE);
      ed = 32'h1234_5678 + 32'(k / 2);
      checks++;
      if (log_q[k].wr !== ((k % 2) == 0) || log_q[k].addr !== ea || log_q[k].data !== ed ||
          log_q[k].strb !== (((k % 2) == 0) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL incr_xfer%0d: got wr=%b addr=%h data=%h strb=%h expected wr=%b addr=%h data=%h",
                 k, log_q[k].wr, log_q[k].addr, log_q[k].data, log_q[k].strb, (k % 2) == 0, ea, ed);
      end
    end
    checks++;
    if (log_q[62].addr !== 32'h8000_007C || log_q[62].data !== 32'h1234_5697) begin
      errors++;
      $display("FAIL incr_last_write: got %h@%h expected 12345697@8000007c", log_q[62].data, log_q[62].addr);
    end
    checks++;
    if ({pass_o, timeout_o, err_cnt_o, fail_addr_o, fail_data_o} !== {1'b1, 1'b0, 16'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL incr_result: got pass=%b tmo=%b err=%0d fa=%h fd=%h expected pass=1 rest 0",
               pass_o, timeout_o, err_cnt_o, fail_addr_o, fail_data_o);
    end
    checks++;
    if (proto_viol != 0) begin errors++; $display("FAIL incr_protocol: got %0d violations expected 0", proto_viol); end
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o, pass_o} !== 3'b001) begin
      errors++; $display("FAIL incr_done_pulse: got done/busy/pass=%b expected 001", {done_o, busy_o, pass_o});
    end
  endtask

  task automatic test_walk1_block();
    int cyc; logic b1; int j; logic [31:0] one, ed;
    one = 32'h1;
    wait_states = 3;
    run(DHS_BIST_WALK1, 1'b1, 32'h0000_2000, 16'd40, 32'hDEAD_BEEF, 0, cyc, b1);
    wait_states = 0;
    checks++;
    if (cyc !== 480) begin errors++; $display("FAIL walk1_latency: got %0d expected 480", cyc); end
    checks++;
    if (log_q.size() != 80) begin errors++; $display("FAIL walk1_xfer_count: got %0d expected 80", log_q.size()); end
    for (int k = 0; k < 80 && k < log_q.size(); k++) begin
      j  = k % 40;
      ed = one << (j % 32);
      checks++;
      if (log_q[k].wr !== (k < 40) || log_q[k].addr !== 32'h2000 + 32'(4 * j) || log_q[k].data !== ed) begin
        errors++;
        $display("FAIL walk1_xfer%0d: got wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h",
                 k, log_q[k].wr, log_q[k].addr, log_q[k].data, k < 40, 32'h2000 + 32'(4 * j), ed);
      end
    end
    checks++;
    if (log_q[33].data !== 32'h0000_0002 || log_q[73].data !== 32'h0000_0002) begin
      errors++; $display("FAIL walk1_word33: got %h/%h expected 00000002", log_q[33].data, log_q[73].data);
    end
    checks++;
    if (pass_o !== 1'b1 || err_cnt_o !== 16'd0) begin
      errors++; $display("FAIL walk1_result: got pass=%b err=%0d expected pass=1 err=0", pass_o, err_cnt_o);
    end
    checks++;
    if (proto_viol != 0) begin errors++; $display("FAIL walk1_protocol: got %0d violations expected 0", proto_viol); end
  endtask

  task automatic test_addr_mismatch();
    int cyc; logic b1;
    corrupt_en = 1; corrupt_addr = 32'h114;
    run(DHS_BIST_ADDR, 1'b0, 32'h0000_0100, 16'd8, 32'hFFFF_FFFF, 0, cyc, b1);
    corrupt_en = 0;
    checks++;
    if (cyc !== 48) begin errors++; $display("FAIL addr_latency: got %0d expected 48", cyc); end
    checks++;
    if ({err_cnt_o, fail_addr_o, fail_data_o, pass_o, timeout_o} !== {16'd1, 32'h114, 32'h115, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL addr_result: got err=%0d fa=%h fd=%h pass=%b tmo=%b expected err=1 fa=114 fd=115 pass=0 tmo=0",
               err_cnt_o, fail_addr_o, fail_data_o, pass_o, timeout_o);
    end
  endtask

  task automatic test_write_slverr();
    int cyc; logic b1;
    wr_err_en = 1; wr_err_addr = 32'h48;
    run(DHS_BIST_INCR, 1'b0, 32'h0000_0040, 16'd4, 32'h0, 0, cyc, b1);
    wr_err_en = 0;
    checks++;
    if (cyc !== 24 || log_q.size() != 8) begin
      errors++; $display("FAIL slverr_run: got cyc=%0d xfers=%0d expected cyc=24 xfers=8", cyc, log_q.size());
    end
    checks++;
    if (log_q[7].addr !== 32'h4C || log_q[7].data !== 32'h3 || log_q[7].wr !== 1'b0) begin
      errors++; $display("FAIL slverr_last_read: got %h@%h expected 00000003@4c", log_q[7].data, log_q[7].addr);
    end
    checks++;
    if ({err_cnt_o, fail_addr_o, fail_data_o, pass_o} !== {16'd1, 32'h48, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL slverr_result: got err=%0d fa=%h fd=%h pass=%b expected err=1 fa=48 fd=0 pass=0",
               err_cnt_o, fail_addr_o, fail_data_o, pass_o);
    end
  endtask

  task automatic test_timeout();
    int cyc; logic b1;
    hang = 1;
    run(DHS_BIST_INCR, 1'b0, 32'h0000_0500, 16'd4, 32'h0, 0, cyc, b1);
    hang = 0;
    checks++;
    if (cyc !== 18 || acc_cycles != 16) begin
      errors++; $display("FAIL timeout_timing: got cyc=%0d access=%0d expected cyc=18 access=16", cyc, acc_cycles);
    end
    checks++;
    if ({timeout_o, pass_o, err_cnt_o, psel_o} !== {1'b1, 1'b0, 16'd0, 1'b0} || log_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_result: got tmo=%b pass=%b err=%0d psel=%b xfers=%0d expected tmo=1 pass=0 err=0 psel=0 xfers=0",
               timeout_o, pass_o, err_cnt_o, psel_o, log_q.size());
    end
    @(negedge clk_i);
    checks++;
    if (timeout_o !== 1'b1 || psel_o !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: got tmo=%b psel=%b expected tmo=1 psel=0", timeout_o, psel_o);
    end
  endtask

  task automatic test_restart_wrap();
    int cyc; logic b1;
    run(DHS_BIST_INCR, 1'b0, 32'hFFFF_FFFC, 16'd2, 32'h0000_0010, 3, cyc, b1);
    checks++;
    if (cyc !== 12 || log_q.size() != 4) begin
      errors++; $display("FAIL restart_run: got cyc=%0d xfers=%0d expected cyc=12 xfers=4", cyc, log_q.size());
    end
    checks++;
    if (log_q[0].addr !== 32'hFFFF_FFFC || log_q[2].addr !== 32'h0 || log_q[2].data !== 32'h11) begin
      errors++;
      $display("FAIL restart_wrap: got %h@%h %h@%h expected 00000010@fffffffc 00000011@00000000",
               log_q[0].data, log_q[0].addr, log_q[2].data, log_q[2].addr);
    end
    checks++;
    if ({timeout_o, pass_o, err_cnt_o} !== {1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL restart_result: got tmo=%b pass=%b err=%0d expected tmo=0 pass=1 err=0",
                         timeout_o, pass_o, err_cnt_o);
    end
  endtask

  task automatic test_reset_mid_access();
    int cyc; logic b1; bit seen;
    seen = 0;
    wait_states = 3;
    @(negedge clk_i);
    mode_i = DHS_BIST_INCR; block_i = 1'b0; base_addr_i = 32'h600;
    num_words_i = 16'd4; seed_i = 32'h0; start_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (psel_o && penable_o) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_access_wait: ACCESS not reached within 50 cycles"); end
    arst_i = 1'b1;
    #1;
    checks++;
    if (out_vec() !== '0) begin errors++; $display("FAIL rst_async: got %h expected 0", out_vec()); end
    repeat (2) @(negedge clk_i);
    checks++;
    if (out_vec() !== '0) begin errors++; $display("FAIL rst_held: got %h expected 0", out_vec()); end
    arst_i = 1'b0;
    wait_states = 0;
    run(DHS_BIST_INCR, 1'b0, 32'h0, 16'd0, 32'h0, 0, cyc, b1);
    checks++;
    if (cyc !== 1 || b1 !== 1'b0 || psel_cycles != 0) begin
      errors++; $display("FAIL zero_words_run: got cyc=%0d busy=%b psel_cycles=%0d expected cyc=1 busy=0 psel_cycles=0",
                         cyc, b1, psel_cycles);
    end
    checks++;
    if ({pass_o, err_cnt_o, timeout_o} !== {1'b1, 16'd0, 1'b0}) begin
      errors++; $display("FAIL zero_words_result: got pass=%b err=%0d tmo=%b expected pass=1 err=0 tmo=0",
                         pass_o, err_cnt_o, timeout_o);
    end
  endtask

  initial begin
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    test_reset();
    test_incr_interleaved();
    test_walk1_block();
    test_addr_mismatch();
    test_write_slverr();
    test_timeout();
    test_restart_wrap();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
